// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
package shift_seq_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   // Shift modes; 2'b11 is decoded as a logical shift
   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_ROR = 2'b10;

   // Bit entering the MSB on a right shift, chosen by mode
   function automatic logic fill_bit(input logic [1:0] mode, input logic msb, input logic lsb);
      logic fill;
      case (mode)
         MODE_ASR: fill = msb;
         MODE_ROR: fill = lsb;
         default:  fill = 1'b0;
      endcase
      return fill;
   endfunction

endpackage

// File: rtl/shift_bit_cell.sv
// One bit of the shift register: load/shift mux in front of a flop.
module shift_bit_cell (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic shift,
   input  logic load_val,
   input  logic in,
   output logic q
);

   logic q_q;
   logic q_d;

   // Load wins over shift; otherwise hold
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (shift) begin
         q_d = in;
      end
   end

   // Storage flop, synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer around a WIDTH-bit right-shift register.
// Accepts {data, count, mode}, performs count single-bit shifts, then
// holds the result until the consumer takes it.
module shift_sequencer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [1:0]       cmd_mode,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             shift_strobe,
   output logic             serial_out,
   output logic             busy
);

   import shift_seq_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] remaining_q;
   logic [1:0]       mode_q;
   logic             cmd_ready_q;
   logic             res_valid_q;
   logic             shift_strobe_q;
   logic             busy_q;

   logic [WIDTH-1:0] sr_q;
   logic             load;
   logic             shift;
   logic             fill;

   // Datapath controls: load only on an accepted command, shift every SHIFT cycle
   assign load  = cmd_valid && (state_q == IDLE);
   assign shift = (state_q == SHIFT);
   assign fill  = fill_bit(mode_q, sr_q[WIDTH-1], sr_q[0]);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic in_bit;
      if (i == WIDTH - 1) begin : g_msb
         assign in_bit = fill;
      end else begin : g_lower
         assign in_bit = sr_q[i+1];
      end

      shift_bit_cell u_cell (
         .clock    (clock),
         .reset_n  (reset_n),
         .load     (load),
         .shift    (shift),
         .load_val (cmd_data[i]),
         .in       (in_bit),
         .q        (sr_q[i])
      );
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = (cmd_count == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // remaining counts the shift happening at this edge
            if (remaining_q == CNT_ONE) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, command latches and registered status outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         remaining_q    <= '0;
         mode_q         <= MODE_LSR;
         cmd_ready_q    <= 1'b1;
         res_valid_q    <= 1'b0;
         shift_strobe_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            remaining_q <= cmd_count;
            mode_q      <= cmd_mode;
         end else if (shift) begin
            remaining_q <= remaining_q - CNT_ONE;
         end
         // Outputs track the state being entered so they align with state_q
         cmd_ready_q    <= (state_d == IDLE);
         res_valid_q    <= (state_d == DONE);
         shift_strobe_q <= (state_d == SHIFT);
         busy_q         <= (state_d != IDLE);
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign res_valid    = res_valid_q;
   assign shift_strobe = shift_strobe_q;
   assign busy         = busy_q;
   assign res_data     = sr_q;
   assign serial_out   = sr_q[0];

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer.
module tb_shift_sequencer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_data = '0;
   logic [CNT_W-1:0] cmd_count = '0;
   logic [1:0]       cmd_mode = 2'b00;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH-1:0] res_data;
   logic             shift_strobe;
   logic             serial_out;
   logic             busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   shift_sequencer #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_data     (cmd_data),
      .cmd_count    (cmd_count),
      .cmd_mode     (cmd_mode),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .shift_strobe (shift_strobe),
      .serial_out   (serial_out),
      .busy         (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      int         count;
      logic [1:0] mode;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[8];

   // Result of n right shifts, computed in closed form
   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int n,
                                              input logic [1:0] m);
      int r;
      logic [WIDTH-1:0] res;
      case (m)
         2'b01: begin
            if (n >= WIDTH) res = {WIDTH{d[WIDTH-1]}};
            else res = WIDTH'($signed(d) >>> n);
         end
         2'b10: begin
            r = n % WIDTH;
            if (r == 0) res = d;
            else res = WIDTH'((d >> r) | (d << (WIDTH - r)));
         end
         default: begin
            if (n >= WIDTH) res = '0;
            else res = WIDTH'(d >> n);
         end
      endcase
      return res;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue one command, follow every shift cycle, stall in DONE, then take the result
   task automatic run_cmd(input logic [7:0] d, input int n, input logic [1:0] m,
                          input logic [7:0] exp, input int stall, input string tag);
      logic [7:0] mv;
      check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_count = n[CNT_W-1:0];
      cmd_mode  = m;
      res_ready = 1'b0;
      step();
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
      for (int k = 0; k < n; k++) begin
         mv = model(d, k, m);
         check({tag, " strobe"}, 32'(shift_strobe), 32'd1);
         check({tag, " serial_out"}, 32'(serial_out), 32'(mv[0]));
         check({tag, " res_valid early"}, 32'(res_valid), 32'd0);
         check({tag, " busy shift"}, 32'(busy), 32'd1);
         step();
      end
      check({tag, " res_valid"}, 32'(res_valid), 32'd1);
      check({tag, " strobe done"}, 32'(shift_strobe), 32'd0);
      check({tag, " res_data"}, 32'(res_data), 32'(exp));
      check({tag, " busy done"}, 32'(busy), 32'd1);
      for (int s = 0; s < stall; s++) begin
         step();
         check({tag, " stall valid"}, 32'(res_valid), 32'd1);
         check({tag, " stall data"}, 32'(res_data), 32'(exp));
         check({tag, " stall cmd_ready"}, 32'(cmd_ready), 32'd0);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check({tag, " res_valid after"}, 32'(res_valid), 32'd0);
      check({tag, " cmd_ready after"}, 32'(cmd_ready), 32'd1);
      check({tag, " busy after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int acc1;
      int acc2;
      int done1;
      int nres;
      logic [7:0] r [2];
      logic [7:0] d;
      int n;
      logic [1:0] m;

      vecs[0] = '{8'b1001_0110, 3, 2'b00, 8'b0001_0010};
      vecs[1] = '{8'b1000_0001, 4, 2'b01, 8'b1111_1000};
      vecs[2] = '{8'b1000_0001, 4, 2'b11, 8'b0000_1000};
      vecs[3] = '{8'hA5, 9, 2'b10, 8'hD2};
      vecs[4] = '{8'h3C, 0, 2'b00, 8'h3C};
      vecs[5] = '{8'hF0, 8, 2'b00, 8'h00};
      vecs[6] = '{8'h80, 15, 2'b01, 8'hFF};
      vecs[7] = '{8'h01, 1, 2'b10, 8'h80};

      // Reset state
      reset_n = 1'b0;
      step();
      step();
      check("rst res_valid", 32'(res_valid), 32'd0);
      check("rst strobe", 32'(shift_strobe), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst serial_out", 32'(serial_out), 32'd0);
      check("rst res_data", 32'(res_data), 32'd0);
      reset_n = 1'b1;
      step();

      // Directed vectors
      foreach (vecs[i]) begin
         run_cmd(vecs[i].data, vecs[i].count, vecs[i].mode, vecs[i].exp, 0, $sformatf("vec%0d", i));
      end

      // Backpressure: 5 stalled cycles with a competing command offered
      cmd_valid = 1'b1;
      cmd_data  = 8'h96;
      cmd_count = 4'd2;
      cmd_mode  = 2'b00;
      step();
      cmd_data  = 8'hFF;
      cmd_count = 4'd1;
      step();
      step();
      check("bp res_valid", 32'(res_valid), 32'd1);
      check("bp res_data", 32'(res_data), 32'h25);
      for (int s = 0; s < 5; s++) begin
         step();
         check("bp stall data", 32'(res_data), 32'h25);
         check("bp stall cmd_ready", 32'(cmd_ready), 32'd0);
         check("bp stall valid", 32'(res_valid), 32'd1);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("bp idle cmd_ready", 32'(cmd_ready), 32'd1);
      check("bp not loaded yet", 32'(res_data), 32'h25);
      step();
      cmd_valid = 1'b0;
      check("bp late accept data", 32'(res_data), 32'hFF);
      check("bp late accept strobe", 32'(shift_strobe), 32'd1);
      step();
      check("bp late result", 32'(res_data), 32'h7F);
      check("bp late valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;

      // Reset on the third shift edge of a count-7 command
      cmd_valid = 1'b1;
      cmd_data  = 8'hC3;
      cmd_count = 4'd7;
      cmd_mode  = 2'b10;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("mid rst res_valid", 32'(res_valid), 32'd0);
      check("mid rst strobe", 32'(shift_strobe), 32'd0);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid rst serial_out", 32'(serial_out), 32'd0);
      check("mid rst res_data", 32'(res_data), 32'd0);
      for (int s = 0; s < 8; s++) begin
         step();
         check("post rst no result", 32'(res_valid), 32'd0);
      end
      run_cmd(8'h5A, 5, 2'b00, 8'h02, 0, "post_rst");

      // Back-to-back with valid and ready held high
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_data  = 8'h96;
      cmd_count = 4'd2;
      cmd_mode  = 2'b00;
      acc1 = -1;
      acc2 = -1;
      done1 = -1;
      nres = 0;
      for (int t = 0; t < 30 && nres < 2; t++) begin
         if (res_valid) begin
            r[nres] = res_data;
            nres++;
         end
         if (cmd_valid && cmd_ready) begin
            if (acc1 < 0) acc1 = cyc + 1;
            else acc2 = cyc + 1;
         end
         step();
         if (res_valid && done1 < 0) done1 = cyc;
         if (acc2 >= 0) cmd_valid = 1'b0;
         else if (acc1 >= 0) begin
            cmd_data  = 8'h81;
            cmd_count = 4'd3;
            cmd_mode  = 2'b01;
         end
      end
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      check("b2b results seen", 32'(nres), 32'd2);
      check("b2b result0", 32'(r[0]), 32'h25);
      check("b2b result1", 32'(r[1]), 32'hF0);
      check("b2b period", 32'(acc2 - acc1), 32'd4);
      check("b2b accept after done", 32'(acc2 - done1), 32'd2);
      step();

      // Randomized commands against the closed-form model
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         n = int'($urandom_range(0, 15));
         m = 2'($urandom_range(0, 3));
         run_cmd(d, n, m, model(d, n, m), int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
